// File: rtl/twdl_pkg.sv
// Shared constants, types and the round/saturate arithmetic used by both the
// twiddle power chain and the lane multipliers.
package twdl_pkg;

    localparam int unsigned CPLX_W = 30;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    // Unity twiddle value for a given number of fraction bits.
    function automatic int tw_one(input int unsigned frac);
        return 1 << frac;
    endfunction

    function automatic int unsigned lat_of(input int unsigned nch);
        return nch + 1;
    endfunction

    function automatic logic signed [63:0] rnd_half_up(input logic signed [63:0] x,
                                                       input int unsigned frac);
        return (x + (64'sd1 <<< (frac - 1))) >>> frac;
    endfunction

    function automatic logic sat_ovf(input logic signed [63:0] x, input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (x > hi) || (x < lo);
    endfunction

    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] x,
                                                    input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/twdl_mult_nch_cmult_rnd.sv
// Complex multiply with round-half-up and saturation back to the A width.
// PIPE=1 registers only the result; PIPE=3 registers products, sums and result.
module cmult_rnd
    import twdl_pkg::*;
#(
    parameter int unsigned W_A  = 30,
    parameter int unsigned W_B  = 16,
    parameter int unsigned FRAC = 14,
    parameter int unsigned PIPE = 3
) (
    input  logic                  clk,
    input  logic signed [W_A-1:0] a_re,
    input  logic signed [W_A-1:0] a_im,
    input  logic signed [W_B-1:0] b_re,
    input  logic signed [W_B-1:0] b_im,
    output logic signed [W_A-1:0] y_re,
    output logic signed [W_A-1:0] y_im,
    output logic                  ovf
);

    localparam int unsigned W_P = W_A + W_B;
    localparam int unsigned W_S = W_P + 1;

    logic signed [W_P-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [W_S-1:0] s_re, s_im;
    logic signed [63:0]    r_re, r_im;

    if (PIPE >= 3) begin : g_deep
        always_ff @(posedge clk) begin
            p_rr <= W_P'(a_re) * W_P'(b_re);
            p_ii <= W_P'(a_im) * W_P'(b_im);
            p_ri <= W_P'(a_re) * W_P'(b_im);
            p_ir <= W_P'(a_im) * W_P'(b_re);
            s_re <= W_S'(p_rr) - W_S'(p_ii);
            s_im <= W_S'(p_ri) + W_S'(p_ir);
        end
    end else begin : g_flat
        always_comb begin
            p_rr = W_P'(a_re) * W_P'(b_re);
            p_ii = W_P'(a_im) * W_P'(b_im);
            p_ri = W_P'(a_re) * W_P'(b_im);
            p_ir = W_P'(a_im) * W_P'(b_re);
            s_re = W_S'(p_rr) - W_S'(p_ii);
            s_im = W_S'(p_ri) + W_S'(p_ir);
        end
    end

    always_comb begin
        r_re = rnd_half_up(64'(s_re), FRAC);
        r_im = rnd_half_up(64'(s_im), FRAC);
    end

    always_ff @(posedge clk) begin
        y_re <= W_A'(sat_clip(r_re, W_A));
        y_im <= W_A'(sat_clip(r_im, W_A));
        ovf  <= sat_ovf(r_re, W_A) | sat_ovf(r_im, W_A);
    end

endmodule

// File: rtl/twdl_mult_nch.sv
// NCH-lane twiddle multiply: lane k is multiplied by W^k, with per-sample bypass,
// lane masking, rounding, saturation and a fixed NCH+1 cycle latency.
module twdl_mult_nch
    import twdl_pkg::*;
#(
    parameter int unsigned NCH     = 5,
    parameter int unsigned W_DATA  = 30,
    parameter int unsigned W_TW    = 16,
    parameter int unsigned TW_FRAC = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_val,
    input  logic                    bypass,
    input  logic [3:0]              nlanes,
    input  logic [W_TW-1:0]         tw_real,
    input  logic [W_TW-1:0]         tw_imag,
    input  logic [NCH*W_DATA-1:0]   din_real,
    input  logic [NCH*W_DATA-1:0]   din_imag,
    output logic                    out_val,
    output logic [NCH*W_DATA-1:0]   dout_real,
    output logic [NCH*W_DATA-1:0]   dout_imag,
    output logic                    sat,
    output logic                    sat_sticky
);

    localparam int unsigned LAT = lat_of(NCH);
    localparam int unsigned DLY = NCH - 2;
    localparam logic signed [W_TW-1:0] ONE = W_TW'(tw_one(TW_FRAC));

    logic [LAT:0] v_pipe;
    logic [DLY:0] byp_pipe;
    logic [3:0]   nl_pipe [LAT+1];
    logic [3:0]   nl_eff;
    logic         sticky;
    logic         sat_c;

    logic signed [W_DATA-1:0] d_re [DLY+1][NCH];
    logic signed [W_DATA-1:0] d_im [DLY+1][NCH];
    logic signed [W_DATA-1:0] l0_re [3];
    logic signed [W_DATA-1:0] l0_im [3];
    logic signed [W_TW-1:0]   w1_re [DLY];
    logic signed [W_TW-1:0]   w1_im [DLY];
    logic signed [W_TW-1:0]   pw_re [NCH-1:2];
    logic signed [W_TW-1:0]   pw_im [NCH-1:2];
    logic signed [W_DATA-1:0] ln_re [NCH-1:1];
    logic signed [W_DATA-1:0] ln_im [NCH-1:1];
    logic                     ln_ovf [NCH-1:1];

    always_comb begin
        nl_eff = nlanes;
        if (nlanes <= 4'd1) nl_eff = 4'd1;
        else if (nlanes > 4'(NCH)) nl_eff = 4'(NCH);
    end

    // Valid and mode travel with the sample; stage i holds data sampled i+1 edges ago.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_pipe   <= '0;
            byp_pipe <= '0;
            sticky   <= 1'b0;
            for (int unsigned i = 0; i <= LAT; i++) nl_pipe[i] <= '0;
        end else begin
            v_pipe     <= {v_pipe[LAT-1:0], in_val};
            byp_pipe   <= {byp_pipe[DLY-1:0], bypass};
            nl_pipe[0] <= nl_eff;
            for (int unsigned i = 1; i <= LAT; i++) nl_pipe[i] <= nl_pipe[i-1];
            if (sat_c) sticky <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NCH; k++) begin
            d_re[0][k] <= din_real[k*W_DATA +: W_DATA];
            d_im[0][k] <= din_imag[k*W_DATA +: W_DATA];
            for (int unsigned j = 1; j <= DLY; j++) begin
                d_re[j][k] <= d_re[j-1][k];
                d_im[j][k] <= d_im[j-1][k];
            end
        end
        l0_re[0] <= d_re[DLY][0];
        l0_im[0] <= d_im[DLY][0];
        for (int unsigned i = 1; i < 3; i++) begin
            l0_re[i] <= l0_re[i-1];
            l0_im[i] <= l0_im[i-1];
        end
        w1_re[0] <= tw_real;
        w1_im[0] <= tw_imag;
        for (int unsigned j = 1; j < DLY; j++) begin
            w1_re[j] <= w1_re[j-1];
            w1_im[j] <= w1_im[j-1];
        end
    end

    // W^k = W^(k-1) * W, with the base W delayed to meet each chain stage.
    for (genvar k = 2; k < NCH; k++) begin : g_pow
        logic signed [W_TW-1:0] a_re, a_im;
        if (k == 2) begin : g_first
            assign a_re = w1_re[0];
            assign a_im = w1_im[0];
        end else begin : g_next
            assign a_re = pw_re[k-1];
            assign a_im = pw_im[k-1];
        end
        cmult_rnd #(.W_A(W_TW), .W_B(W_TW), .FRAC(TW_FRAC), .PIPE(1)) u_pow (
            .clk  (clk),
            .a_re (a_re),
            .a_im (a_im),
            .b_re (w1_re[k-2]),
            .b_im (w1_im[k-2]),
            .y_re (pw_re[k]),
            .y_im (pw_im[k]),
            .ovf  ()
        );
    end

    // Lower powers are ready early and are held back so every lane starts together.
    for (genvar k = 1; k < NCH; k++) begin : g_lane
        localparam int unsigned D = NCH - 1 - k;
        logic signed [W_TW-1:0] src_re, src_im, tw_re, tw_im, b_re, b_im;
        if (k == 1) begin : g_w1
            assign src_re = w1_re[0];
            assign src_im = w1_im[0];
        end else begin : g_wk
            assign src_re = pw_re[k];
            assign src_im = pw_im[k];
        end
        if (D == 0) begin : g_nodly
            assign tw_re = src_re;
            assign tw_im = src_im;
        end else begin : g_dly
            logic signed [W_TW-1:0] sr_re [D];
            logic signed [W_TW-1:0] sr_im [D];
            always_ff @(posedge clk) begin
                sr_re[0] <= src_re;
                sr_im[0] <= src_im;
                for (int unsigned i = 1; i < D; i++) begin
                    sr_re[i] <= sr_re[i-1];
                    sr_im[i] <= sr_im[i-1];
                end
            end
            assign tw_re = sr_re[D-1];
            assign tw_im = sr_im[D-1];
        end
        assign b_re = byp_pipe[DLY] ? ONE : tw_re;
        assign b_im = byp_pipe[DLY] ? '0  : tw_im;
        cmult_rnd #(.W_A(W_DATA), .W_B(W_TW), .FRAC(TW_FRAC), .PIPE(3)) u_mul (
            .clk  (clk),
            .a_re (d_re[DLY][k]),
            .a_im (d_im[DLY][k]),
            .b_re (b_re),
            .b_im (b_im),
            .y_re (ln_re[k]),
            .y_im (ln_im[k]),
            .ovf  (ln_ovf[k])
        );
    end

    always_comb begin
        dout_real = '0;
        dout_imag = '0;
        sat_c     = 1'b0;
        if (v_pipe[LAT]) begin
            dout_real[0 +: W_DATA] = l0_re[2];
            dout_imag[0 +: W_DATA] = l0_im[2];
            for (int unsigned k = 1; k < NCH; k++) begin
                if (k < 32'(nl_pipe[LAT])) begin
                    dout_real[k*W_DATA +: W_DATA] = ln_re[k];
                    dout_imag[k*W_DATA +: W_DATA] = ln_im[k];
                    sat_c = sat_c | ln_ovf[k];
                end
            end
        end
    end

    assign out_val    = v_pipe[LAT];
    assign sat        = sat_c;
    assign sat_sticky = sticky | sat_c;

endmodule

// File: tb/tb_twdl_mult_nch.sv
// Scoreboard bench for twdl_mult_nch: directed vectors push expectations,
// a negedge monitor pops and compares whenever out_val is seen.
module tb_twdl_mult_nch;
    import twdl_pkg::*;

    localparam int NCH = 5;
    localparam int W   = 30;
    localparam int WT  = 16;
    localparam int LAT = NCH + 1;
    localparam int M   = (1 << 29) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, in_val, bypass;
    logic [3:0]           nlanes;
    logic [WT-1:0]        tw_real, tw_imag;
    logic [NCH*W-1:0]     din_real, din_imag;
    logic                 out_val, sat, sat_sticky;
    logic [NCH*W-1:0]     dout_real, dout_imag;

    twdl_mult_nch #(.NCH(NCH), .W_DATA(W), .W_TW(WT), .TW_FRAC(14)) dut (
        .clk(clk), .rst(rst), .in_val(in_val), .bypass(bypass), .nlanes(nlanes),
        .tw_real(tw_real), .tw_imag(tw_imag), .din_real(din_real), .din_imag(din_imag),
        .out_val(out_val), .dout_real(dout_real), .dout_imag(dout_imag),
        .sat(sat), .sat_sticky(sat_sticky)
    );

    typedef struct {
        int unsigned      due;
        logic [NCH*W-1:0] re;
        logic [NCH*W-1:0] im;
        logic             sat;
    } exp_t;

    exp_t        q[$];
    exp_t        mexp;
    cplx_t       stim [NCH];
    cplx_t       expv [NCH];
    int unsigned edge_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [NCH*W-1:0] got,
                         input logic [NCH*W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic cplx_t mk(input int re, input int im);
        cplx_t c;
        c.re = CPLX_W'(re);
        c.im = CPLX_W'(im);
        return c;
    endfunction

    // Data times j^k
    function automatic cplx_t rot_j(input int a, input int k);
        case (k % 4)
            0: return mk(a, 0);
            1: return mk(0, a);
            2: return mk(-a, 0);
            default: return mk(0, -a);
        endcase
    endfunction

    task automatic issue(input logic byp, input logic [3:0] nl, input int twr, input int twi,
                         input logic r, input logic push, input logic esat);
        exp_t e;
        int   ne;
        @(negedge clk);
        rst = r; in_val = 1'b1; bypass = byp; nlanes = nl;
        tw_real = WT'(twr); tw_imag = WT'(twi);
        for (int k = 0; k < NCH; k++) begin
            din_real[k*W +: W] = stim[k].re;
            din_imag[k*W +: W] = stim[k].im;
        end
        if (push) begin
            ne = (nl <= 1) ? 1 : (nl > NCH) ? NCH : int'(nl);
            e.due = edge_cnt + 1 + LAT;
            e.re = '0; e.im = '0; e.sat = esat;
            for (int k = 0; k < ne; k++) begin
                e.re[k*W +: W] = expv[k].re;
                e.im[k*W +: W] = expv[k].im;
            end
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rst = 1'b0; in_val = 1'b0;
            bypass = ~bypass; nlanes = ~nlanes;
            tw_real = ~tw_real; din_real = ~din_real; din_imag = ~din_imag;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].due < edge_cnt) begin
                n_chk++; n_fail++;
                $display("FAIL missing_out got=none exp=edge %0d", q[0].due);
                void'(q.pop_front());
            end
            if (out_val) begin
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_out_val got=1 exp=0 at edge %0d", edge_cnt);
                end else begin
                    mexp = q.pop_front();
                    check("latency_edge", edge_cnt, mexp.due);
                    check("dout_real", dout_real, mexp.re);
                    check("dout_imag", dout_imag, mexp.im);
                    check("sat", sat, mexp.sat);
                end
            end else begin
                check("idle_real", dout_real, '0);
                check("idle_imag", dout_imag, '0);
                check("idle_sat", sat, 1'b0);
            end
        end
    end

    initial begin
        rst = 1'b1; in_val = 1'b0; bypass = 1'b0; nlanes = 4'd5;
        tw_real = '0; tw_imag = '0; din_real = '0; din_imag = '0;
        repeat (3) @(negedge clk);
        check("rst_out_val", out_val, 1'b0);
        check("rst_dout_real", dout_real, '0);
        check("rst_sat", sat, 1'b0);
        check("rst_sat_sticky", sat_sticky, 1'b0);
        rst = 1'b0;
        mon_en = 1'b1;
        idle(5);

        // Bypass: output equals input
        for (int k = 0; k < NCH; k++) begin
            stim[k] = mk(1000 * k, -1000 * k);
            expv[k] = stim[k];
        end
        issue(1'b1, 4'd5, 12345, -777, 1'b0, 1'b1, 1'b0);
        idle(LAT + 2);

        // Twiddle = j
        for (int k = 0; k < NCH; k++) begin
            stim[k] = mk(100, 0);
            expv[k] = rot_j(100, k);
        end
        issue(1'b0, 4'd5, 0, 16384, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Rounding with W=0.5, W^2=0.25
        for (int k = 0; k < NCH; k++) begin
            stim[k] = mk(0, 0);
            expv[k] = mk(0, 0);
        end
        stim[1] = mk(3, -3); stim[2] = mk(3, -3);
        expv[1] = mk(2, -1); expv[2] = mk(1, -1);
        issue(1'b0, 4'd5, 8192, 0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Saturation with W=1+j
        for (int k = 0; k < NCH; k++) begin
            stim[k] = mk(0, 0);
            expv[k] = mk(0, 0);
        end
        stim[1] = mk(M, M);
        expv[1] = mk(0, M);
        issue(1'b0, 4'd5, 16384, 16384, 1'b0, 1'b1, 1'b1);
        // Same sample with lane 1 masked: no sat reported
        issue(1'b0, 4'd1, 16384, 16384, 1'b0, 1'b1, 1'b0);
        idle(LAT + 3);
        check("sat_sticky_hold", sat_sticky, 1'b1);

        // Back-to-back, alternating bypass, cycling nlanes, plus clamp cases
        for (int s = 0; s < 10; s++) begin
            logic       byp;
            logic [3:0] nl;
            int         a;
            byp = 1'(s % 2);
            nl  = (s < 8) ? ((s % 3 == 0) ? 4'd5 : (s % 3 == 1) ? 4'd3 : 4'd2)
                          : ((s == 8) ? 4'd0 : 4'd12);
            a   = 10 * (s + 1);
            for (int k = 0; k < NCH; k++) begin
                if (byp) begin
                    stim[k] = mk(a + k, -(a + k));
                    expv[k] = stim[k];
                end else begin
                    stim[k] = mk(a, 0);
                    expv[k] = rot_j(a, k);
                end
            end
            issue(byp, nl, 0, 16384, 1'b0, 1'b1, 1'b0);
        end
        idle(LAT + 2);

        // Reset mid-stream: burst dropped, sample right after reset survives
        for (int k = 0; k < NCH; k++) begin
            stim[k] = mk(7 * k + 1, -5 * k);
            expv[k] = stim[k];
        end
        issue(1'b0, 4'd5, 0, 16384, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 4'd5, 0, 16384, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 4'd3, 0, 16384, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 4'd5, 0, 16384, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 4'd4, 0, 16384, 1'b0, 1'b1, 1'b0);
        idle(2);
        check("sat_sticky_cleared", sat_sticky, 1'b0);
        idle(LAT + 2);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain got=%0d pending exp=0", q.size());
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/twdl_mult_nch.md
Name: twdl_mult_nch

Overview:
- Parametrised successor to the mixed-radix twiddle-multiply stage of the FFT datapath.
- Takes one NCH-lane butterfly vector per cycle plus one base twiddle W, and multiplies lane k by W^k.
- Powers W^2..W^(NCH-1) come from an internal pipelined recursive chain.
- Adds a per-sample active-lane count, a bypass with the same latency as the multiply path, rounding, saturation, and a fixed latency in all modes. It sits between the radix butterfly and the next column's reorder buffer.

Parameters:
- NCH, 5, lane count (3..8); lane 0 is always unity.
- W_DATA, 30, signed data width per real/imag component.
- W_TW, 16, signed twiddle width.
- TW_FRAC, 14, twiddle fraction bits; 1.0 = 2^TW_FRAC.
- LAT, NCH+1, derived localparam, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_val  in  1  input vector valid
- bypass  in  1  per-sample: unity twiddle on all lanes
- nlanes  in  4  per-sample active lane count
- tw_real  in  W_TW  base twiddle real, Q(TW_FRAC)
- tw_imag  in  W_TW  base twiddle imag
- din_real  in  NCH x W_DATA  lane data real
- din_imag  in  NCH x W_DATA  lane data imag
- out_val  out  1  output valid
- dout_real  out  NCH x W_DATA  result real
- dout_imag  out  NCH x W_DATA  result imag
- sat  out  1  any lane saturated in this output
- sat_sticky  out  1  sat OR-accumulated since reset

Behaviour:
- Interface (decided): one clock clk; reset rst is synchronous, active-high.
- Reset values: out_val=0, dout_*=0, sat=0, sat_sticky=0; all internal valid/mode pipeline bits cleared.
- Sampling: all inputs are sampled at the edge where in_val=1; when in_val=0 they are don't-care.
- Latency: sample at edge t gives out_val=1 at edge t+LAT (6 for NCH=5), in all modes. Fully pipelined, one vector per cycle, no stalls.
- bypass, nlanes, twiddle and data travel together in the pipeline, so mode changes take effect per sample with no bubble.
- Power chain:
  - W^1 is registered.
  - Stage k (k=2..NCH-1) registers W^k = round(W^(k-1)·W) in 1 cycle.
  - Chain depth NCH-2 cycles; lane data is delay-matched by shift registers, not a FIFO.
- Power rounding: p = a·b + 2^(TW_FRAC-1), arithmetic shift right TW_FRAC, saturate to W_TW (does not affect sat).
- Lane multiply (lanes 1..NCH-1): 3 registered stages.
  - Stage 1: four products, width W_DATA+W_TW.
  - Stage 2: re = rr−ii, im = ri+ir, width W_DATA+W_TW+1.
  - Stage 3: round half-up (+2^(TW_FRAC-1), >>>TW_FRAC), saturate to [−2^(W_DATA-1), 2^(W_DATA-1)−1].
- Lane 0 passes through the matched delay unchanged.
- bypass=1: twiddle for every lane is forced to exactly 2^TW_FRAC (+0j); output equals input and never saturates.
- Lane masking: lane k outputs 0 when k ≥ nlanes_eff.
  - nlanes_eff = 1 if nlanes ≤ 1.
  - nlanes_eff = NCH if nlanes > NCH.
  - Otherwise nlanes_eff = nlanes.
- Output when out_val=0: dout_*=0 and sat=0.
- sat: OR over active lanes of saturation in the output cycle. sat_sticky sets on sat and clears only on rst.
- rst mid-stream: in-flight samples are discarded; no out_val for them. The first output appears LAT cycles after the first in_val sampled with rst=0.
- rst and in_val in the same cycle: reset wins and the sample is dropped.

Decomposition:
- Package twdl_pkg holds:
  - TW_ONE(TW_FRAC) constant;
  - LAT function;
  - a cplx_t struct typedef parametrised via localparams;
  - the round-half-up and saturate functions shared by both multiply paths.
- Sub-module cmult_rnd: complex multiply with round/saturate, parameter PIPE (1 for the power chain, 3 for lanes).
  - Instantiated NCH-2 times in the chain and NCH-1 times in the lanes.
  - Emits an overflow flag.

Test Plan:
- bypass=1, nlanes=5, lane k din=(1000k, −1000k), single in_val at cycle 10 → out_val only at cycle 16, dout identical to din, sat=0.
- tw=(0,16384) (=j), all lanes din=(100,0), nlanes=5 → lanes 0..4 = (100,0), (0,100), (−100,0), (0,−100), (100,0).
- Rounding: tw=(8192,0), lane1 din=(3,−3), lane2 din=(3,−3) → lane1=(2,−1), lane2 (W²=4096) gives 0.75 and −0.75 → (1,−1).
- Saturation: tw=(16384,16384), lane1 din=(2^29−1, 2^29−1) → lane1=(0, 2^29−1), sat=1, sat_sticky stays 1 afterwards.
- Back-to-back: 8 consecutive in_val with bypass alternating 0/1 and nlanes cycling 5,3,2 → 8 contiguous out_val cycles, each output matching its own sample's mode; lanes ≥ nlanes are 0.
- Reset mid-stream: 4-sample burst, rst high for 1 cycle two cycles after burst start → no out_val for any burst sample, dout=0. A new sample 1 cycle after rst gives out_val exactly LAT cycles later.
